dram_arbiter: RTL and testbench
===============================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 24, DRAM word address width.
REQ-002 Parameter DATA_W, default 32, data width of each port and of the controller side.
REQ-003 Parameter TIMEOUT, default 1023, maximum number of BUSY cycles before the arbiter aborts a transfer.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 pN_addr, pN_data_in  in  ADDR_W / DATA_W  port N request address and write data (N = 0 is the CPU, N = 1 is DMA).
REQ-007 pN_req_read, pN_req_write  in  1 each  port N level requests, held high until completion is seen.
REQ-008 pN_data_out  out  DATA_W  port N read data.
REQ-009 pN_data_valid, pN_write_complete  out  1 each  port N one-cycle completion pulses.
REQ-010 dram_addr, dram_data_out  out  ADDR_W / DATA_W  address and write data to the SDRAM controller.
REQ-011 dram_req_read, dram_req_write  out  1 each  requests to the SDRAM controller.
REQ-012 dram_data_in  in  DATA_W  read data from the SDRAM controller.
REQ-013 dram_data_valid, dram_write_complete  in  1 each  completion signals from the SDRAM controller.
REQ-014 grant  out  1  index of the port being served; timeout_err  out  1  sticky abort flag.

Function
REQ-015 States are IDLE, BUSY and RELEASE; every output is registered.
REQ-016 IDLE, a port is pending when its req_read or req_write is high.
REQ-017 IDLE, single pending port: that port is granted.
REQ-018 IDLE, both ports pending: the port not granted last is granted (round-robin); after reset, last grant = 1, so port 0 wins the first tie.
REQ-019 IDLE, on grant at edge N: latch grant, pN_addr and pN_data_in into dram_addr/dram_data_out; drive dram_req_write = pN_req_write and dram_req_read = pN_req_read & ~pN_req_write; enter BUSY. Requests are visible from cycle N+1.
REQ-020 When a port asserts read and write together, it is treated as a write only.
REQ-021 BUSY: dram_req_*, dram_addr and dram_data_out are held stable; a changing pN_addr is ignored.
REQ-022 BUSY, read: the first cycle of dram_data_valid latches dram_data_in into p[grant]_data_out, pulses p[grant]_data_valid for exactly 1 cycle on the next edge, drops dram_req_read and enters RELEASE.
REQ-023 BUSY, write: the first cycle of dram_write_complete pulses p[grant]_write_complete for 1 cycle on the next edge, drops dram_req_write and enters RELEASE.
REQ-024 A completion input of the wrong type for the current transfer, or any completion input outside BUSY, is ignored.
REQ-025 A BUSY cycle counter starts at 0 on entry; when it reaches TIMEOUT without completion: set timeout_err; pulse the matching completion with pN_data_out = 0 (reads); drop dram requests; enter RELEASE.
REQ-026 RELEASE: stay until both req inputs of the granted port are low, then go to IDLE. The other port cannot be granted before that IDLE cycle.
REQ-027 pN_data_out holds its last value and is not cleared on completion.
REQ-028 The non-granted port never receives a completion pulse.

Reset
REQ-029 While rst_n = 0, asynchronously: state = IDLE; grant = 0; last grant = 1; timeout counter = 0; timeout_err = 0; all req and pulse outputs = 0; all data and address outputs = 0.
REQ-030 Reset mid-transfer abandons the transfer with no completion pulse; the first grant after release obeys REQ-018.

Verification
REQ-031 Port 0 reads 0x000010 alone; controller returns 0xDEADBEEF 6 cycles after the request -> dram_req_read for 6 cycles, then p0_data_valid pulses 1 cycle with p0_data_out = 0xDEADBEEF.
REQ-032 Both ports write in the same cycle just after reset -> port 0 is served first, then port 1, each gets exactly one write_complete, and grant shows 0 then 1.
REQ-033 Port 0 re-requests immediately after each completion while port 1 stays pending -> grants alternate 0,1,0,1 with no starvation.
REQ-034 Port 1 reads but the controller never answers, TIMEOUT = 15 -> after 15 BUSY cycles timeout_err = 1, p1_data_valid pulses with data 0, and the arbiter returns to IDLE once the port drops its request.
REQ-035 rst_n is pulled low during BUSY -> all outputs are 0 immediately, and no pulses follow after release.
REQ-036 Port 0 holds req_read after data_valid for 3 extra cycles -> the arbiter stays in RELEASE, issues no new controller request, and does not re-grant port 0.

Source files
------------

// File: rtl/dram_arbiter.sv
// Two-port (CPU = port 0, DMA = port 1) round-robin arbiter in front of one SDRAM controller.
// One transfer at a time; a BUSY watchdog aborts transfers the controller never finishes.
module dram_arbiter #(
   parameter int unsigned ADDR_W  = 24,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_data_in,
   input  logic              p0_req_read,
   input  logic              p0_req_write,
   output logic [DATA_W-1:0] p0_data_out,
   output logic              p0_data_valid,
   output logic              p0_write_complete,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_data_in,
   input  logic              p1_req_read,
   input  logic              p1_req_write,
   output logic [DATA_W-1:0] p1_data_out,
   output logic              p1_data_valid,
   output logic              p1_write_complete,
   output logic [ADDR_W-1:0] dram_addr,
   output logic [DATA_W-1:0] dram_data_out,
   output logic              dram_req_read,
   output logic              dram_req_write,
   input  logic [DATA_W-1:0] dram_data_in,
   input  logic              dram_data_valid,
   input  logic              dram_write_complete,
   output logic              grant,
   output logic              timeout_err
);

   // Counter only has to hold 0 .. TIMEOUT-1; TIMEOUT is expected to be at least 1.
   localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   logic              p0_pend, p1_pend, pick, granted_pend;
   logic              sel_read, sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data, rd_data;
   logic              done, expired;

   logic [ADDR_W-1:0] dram_addr_d;
   logic [DATA_W-1:0] dram_data_out_d, p0_data_out_d, p1_data_out_d;
   logic              dram_req_read_d, dram_req_write_d, grant_d, timeout_err_d;
   logic              p0_valid_d, p1_valid_d, p0_wc_d, p1_wc_d;

   assign p0_pend = p0_req_read | p0_req_write;
   assign p1_pend = p1_req_read | p1_req_write;
   // On a tie the port that did not win last time is served.
   assign pick         = (p0_pend && p1_pend) ? ~last_q : p1_pend;
   assign sel_read     = pick ? p1_req_read  : p0_req_read;
   assign sel_write    = pick ? p1_req_write : p0_req_write;
   assign sel_addr     = pick ? p1_addr      : p0_addr;
   assign sel_data     = pick ? p1_data_in   : p0_data_in;
   assign granted_pend = grant ? p1_pend : p0_pend;

   // Only the completion matching the outstanding request type counts.
   assign done    = (dram_req_read & dram_data_valid) | (dram_req_write & dram_write_complete);
   assign expired = ~done & (cnt_q == CntLast);
   assign rd_data = expired ? '0 : dram_data_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:    if (p0_pend || p1_pend) state_d = StBusy;
         StBusy:    if (done || expired)    state_d = StRelease;
         StRelease: if (!granted_pend)      state_d = StIdle;
         default:                           state_d = StIdle;
      endcase
   end

   always_comb begin
      dram_addr_d      = dram_addr;
      dram_data_out_d  = dram_data_out;
      dram_req_read_d  = dram_req_read;
      dram_req_write_d = dram_req_write;
      grant_d          = grant;
      last_d           = last_q;
      cnt_d            = cnt_q;
      timeout_err_d    = timeout_err;
      p0_data_out_d    = p0_data_out;
      p1_data_out_d    = p1_data_out;
      p0_valid_d       = 1'b0;
      p1_valid_d       = 1'b0;
      p0_wc_d          = 1'b0;
      p1_wc_d          = 1'b0;
      case (state_q)
         StIdle: begin
            if (p0_pend || p1_pend) begin
               grant_d          = pick;
               last_d           = pick;
               dram_addr_d      = sel_addr;
               dram_data_out_d  = sel_data;
               dram_req_write_d = sel_write;
               dram_req_read_d  = sel_read & ~sel_write;
               cnt_d            = '0;
            end
         end
         StBusy: begin
            if (done || expired) begin
               dram_req_read_d  = 1'b0;
               dram_req_write_d = 1'b0;
               if (expired) timeout_err_d = 1'b1;
               if (dram_req_read) begin
                  // An aborted read still completes, carrying zero data.
                  if (grant) begin
                     p1_data_out_d = rd_data;
                     p1_valid_d    = 1'b1;
                  end else begin
                     p0_data_out_d = rd_data;
                     p0_valid_d    = 1'b1;
                  end
               end else begin
                  if (grant) p1_wc_d = 1'b1;
                  else       p0_wc_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dram_addr         <= '0;
         dram_data_out     <= '0;
         dram_req_read     <= 1'b0;
         dram_req_write    <= 1'b0;
         grant             <= 1'b0;
         last_q            <= 1'b1;
         cnt_q             <= '0;
         timeout_err       <= 1'b0;
         p0_data_out       <= '0;
         p1_data_out       <= '0;
         p0_data_valid     <= 1'b0;
         p1_data_valid     <= 1'b0;
         p0_write_complete <= 1'b0;
         p1_write_complete <= 1'b0;
      end else begin
         dram_addr         <= dram_addr_d;
         dram_data_out     <= dram_data_out_d;
         dram_req_read     <= dram_req_read_d;
         dram_req_write    <= dram_req_write_d;
         grant             <= grant_d;
         last_q            <= last_d;
         cnt_q             <= cnt_d;
         timeout_err       <= timeout_err_d;
         p0_data_out       <= p0_data_out_d;
         p1_data_out       <= p1_data_out_d;
         p0_data_valid     <= p0_valid_d;
         p1_data_valid     <= p1_valid_d;
         p0_write_complete <= p0_wc_d;
         p1_write_complete <= p1_wc_d;
      end
   end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus random two-port traffic, scored against
// a per-address memory model through per-port expectation queues.
module tb_dram_arbiter;

   localparam int unsigned AW  = 24;
   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 15;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] p0_addr, p1_addr, dram_addr;
   logic [DW-1:0] p0_data_in, p1_data_in, p0_data_out, p1_data_out;
   logic          p0_req_read, p0_req_write, p1_req_read, p1_req_write;
   logic          p0_data_valid, p0_write_complete, p1_data_valid, p1_write_complete;
   logic [DW-1:0] dram_data_out, dram_data_in;
   logic          dram_req_read, dram_req_write, dram_data_valid, dram_write_complete;
   logic          grant, timeout_err;

   typedef struct packed {
      logic          is_read;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          exp_q0[$];
   exp_t          exp_q1[$];
   logic [DW-1:0] ref_mem  [logic [AW-1:0]];
   logic [DW-1:0] dram_mem [logic [AW-1:0]];
   logic          grant_log[$];

   int checks = 0;
   int errors = 0;
   int ctl_mode = 0;
   int fixed_lat = 0;
   bit noise_en = 1'b0;
   int rd_cycles = 0;
   int wr_cycles = 0;
   int rsp_cnt = 0;
   int rsp_lat = 1;
   logic req_prev = 1'b0;

   dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .p0_addr             (p0_addr),
      .p0_data_in          (p0_data_in),
      .p0_req_read         (p0_req_read),
      .p0_req_write        (p0_req_write),
      .p0_data_out         (p0_data_out),
      .p0_data_valid       (p0_data_valid),
      .p0_write_complete   (p0_write_complete),
      .p1_addr             (p1_addr),
      .p1_data_in          (p1_data_in),
      .p1_req_read         (p1_req_read),
      .p1_req_write        (p1_req_write),
      .p1_data_out         (p1_data_out),
      .p1_data_valid       (p1_data_valid),
      .p1_write_complete   (p1_write_complete),
      .dram_addr           (dram_addr),
      .dram_data_out       (dram_data_out),
      .dram_req_read       (dram_req_read),
      .dram_req_write      (dram_req_write),
      .dram_data_in        (dram_data_in),
      .dram_data_valid     (dram_data_valid),
      .dram_write_complete (dram_write_complete),
      .grant               (grant),
      .timeout_err         (timeout_err)
   );

   always #5 clk = ~clk;

   // Contents of never-written DRAM words.
   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      return {8'h5A, a} ^ 32'h0F0F_3C3C;
   endfunction

   function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   function automatic logic [127:0] out_vec();
      return {dram_addr, dram_data_out, p0_data_out, p1_data_out, dram_req_read, dram_req_write,
              p0_data_valid, p1_data_valid, p0_write_complete, p1_write_complete, grant,
              timeout_err};
   endfunction

   function automatic logic [31:0] log_bits();
      logic [31:0] b = '0;
      foreach (grant_log[i]) if (i < 32) b[i] = grant_log[i];
      return b;
   endfunction

   function automatic bit got_pulse(input int p);
      return (p == 0) ? (p0_data_valid | p0_write_complete) : (p1_data_valid | p1_write_complete);
   endfunction

   task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, got, want);
      end
   endtask

   task automatic drive(input int p, input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
      if (p == 0) begin
         p0_req_read = rd; p0_req_write = wr; p0_addr = a; p0_data_in = d;
      end else begin
         p1_req_read = rd; p1_req_write = wr; p1_addr = a; p1_data_in = d;
      end
   endtask

   // Issue one transfer, push its expected completion, hold until completion (+hold cycles).
   task automatic port_xfer(input int p, input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int hold, input bit tmo);
      exp_t e;
      int   n;
      e.is_read = rd & ~wr;
      e.data    = (!e.is_read || tmo) ? '0 : ref_read(a);
      if (!e.is_read) ref_mem[a] = d;
      if (p == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      drive(p, rd, wr, a, d);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!got_pulse(p) && n < 300);
      checks++;
      if (!got_pulse(p)) begin
         errors++;
         $display("FAIL completion_wait port%0d: got no completion in %0d cycles, required one",
                  p, n);
      end
      repeat (hold) begin @(posedge clk); #1; end
      drive(p, 1'b0, 1'b0, a, d);
      @(posedge clk); #1;
   endtask

   task automatic port_loop(input int p, input int count);
      int            r;
      logic [AW-1:0] a;
      for (int i = 0; i < count; i++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         r = $urandom_range(0, 3);
         a = ((p == 1) ? 24'h800000 : 24'h000000) | 24'($urandom_range(0, 15));
         port_xfer(p, (r != 2), (r >= 2), a, $urandom, $urandom_range(0, 2), 1'b0);
      end
   endtask

   task automatic check_port(input int p, input logic v, input logic wc, input logic [DW-1:0] dout);
      exp_t e;
      bit   have;
      if (!(v || wc)) return;
      checks++;
      have = (p == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
      if (!have) begin
         errors++;
         $display("FAIL spurious_pulse port%0d: got valid=%b wc=%b, required no pulse", p, v, wc);
         return;
      end
      if (p == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      if (v !== e.is_read || wc !== !e.is_read || (e.is_read && dout !== e.data) ||
          grant !== 1'(p)) begin
         errors++;
         $display("FAIL pulse_port%0d: got valid=%b wc=%b data=%h grant=%b, required valid=%b wc=%b data=%h grant=%0d",
                  p, v, wc, dout, grant, e.is_read, !e.is_read, e.data, p);
      end
   endtask

   // Scoreboard monitor.
   initial forever begin
      @(posedge clk); #1;
      if (rst_n) begin
         check_port(0, p0_data_valid, p0_write_complete, p0_data_out);
         check_port(1, p1_data_valid, p1_write_complete, p1_data_out);
      end
   end

   // Request-cycle counters and grant log (one entry per controller request start).
   initial forever begin
      logic req_now;
      @(posedge clk); #1;
      if (dram_req_read)  rd_cycles++;
      if (dram_req_write) wr_cycles++;
      req_now = dram_req_read | dram_req_write;
      if (req_now && !req_prev) grant_log.push_back(grant);
      req_prev = req_now;
   end

   // SDRAM controller model: ctl_mode 0 answers after a latency, 1 never answers.
   initial begin
      dram_data_in        = '0;
      dram_data_valid     = 1'b0;
      dram_write_complete = 1'b0;
      forever begin
         @(posedge clk); #1;
         dram_data_valid     = 1'b0;
         dram_write_complete = 1'b0;
         dram_data_in        = $urandom;
         if (!(dram_req_read || dram_req_write)) begin
            rsp_cnt = 0;
            if (noise_en) begin
               dram_data_valid     = ($urandom_range(0, 3) == 0);
               dram_write_complete = ($urandom_range(0, 3) == 0);
            end
         end else begin
            rsp_cnt++;
            if (rsp_cnt == 1) rsp_lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 8);
            if (ctl_mode == 0 && rsp_cnt == rsp_lat) begin
               if (dram_req_read) begin
                  dram_data_in    = dram_mem.exists(dram_addr) ? dram_mem[dram_addr]
                                                               : init_word(dram_addr);
                  dram_data_valid = 1'b1;
               end else begin
                  dram_mem[dram_addr] = dram_data_out;
                  dram_write_complete = 1'b1;
               end
            end else if (noise_en) begin
               if (dram_req_read) dram_write_complete = ($urandom_range(0, 2) == 0);
               else               dram_data_valid     = ($urandom_range(0, 2) == 0);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0);
      ref_mem[24'h000010]  = 32'hDEAD_BEEF;
      dram_mem[24'h000010] = 32'hDEAD_BEEF;
      #3;
      check_val("reset_outputs", out_vec(), '0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check_val("idle_after_reset", out_vec(), '0);

      // Simultaneous writes right after reset: port 0 first, then port 1.
      grant_log.delete();
      fork
         port_xfer(0, 1'b0, 1'b1, 24'h000004, 32'hA0A0_0001, 0, 1'b0);
         port_xfer(1, 1'b0, 1'b1, 24'h800004, 32'hB0B0_0001, 0, 1'b0);
      join
      check_val("tie_count", 128'(grant_log.size()), 128'(2));
      check_val("tie_order", 128'(log_bits()), 128'(32'b10));

      // Both ports keep re-requesting: grants must alternate.
      grant_log.delete();
      fork
         for (int i = 0; i < 3; i++) port_xfer(0, 1'b1, 1'b0, 24'h000004, '0, 0, 1'b0);
         for (int j = 0; j < 3; j++) port_xfer(1, 1'b0, 1'b1, 24'(24'h800008 + j), 32'(j), 0, 1'b0);
      join
      check_val("rr_count", 128'(grant_log.size()), 128'(6));
      check_val("rr_order", 128'(log_bits()), 128'(32'b101010));

      // Lone read, 6-cycle controller latency, port address wiggles during BUSY.
      fixed_lat = 6;
      rd_cycles = 0;
      fork
         port_xfer(0, 1'b1, 1'b0, 24'h000010, '0, 0, 1'b0);
         begin
            n = 0;
            while (!dram_req_read && n < 20) begin @(posedge clk); #1; n++; end
            p0_addr = 24'h000123;
            repeat (3) begin @(posedge clk); #1; end
            check_val("busy_addr_hold", 128'(dram_addr), 128'(24'h000010));
         end
      join
      check_val("read_req_cycles", 128'(rd_cycles), 128'(6));
      repeat (3) begin @(posedge clk); #1; end
      check_val("data_out_holds", 128'(p0_data_out), 128'(32'hDEAD_BEEF));

      // Port 0 holds its request 3 cycles after data_valid: no new grant.
      fixed_lat = 3;
      rd_cycles = 0;
      grant_log.delete();
      port_xfer(0, 1'b1, 1'b0, 24'h000008, '0, 3, 1'b0);
      repeat (4) begin @(posedge clk); #1; end
      check_val("hold_req_cycles", 128'(rd_cycles), 128'(3));
      check_val("hold_no_regrant", 128'(grant_log.size()), 128'(1));
      fixed_lat = 0;

      // Controller never answers port 1's read.
      ctl_mode  = 1;
      rd_cycles = 0;
      grant_log.delete();
      check_val("timeout_err_clear", 128'(timeout_err), 128'(0));
      port_xfer(1, 1'b1, 1'b0, 24'h800040, '0, 0, 1'b1);
      check_val("timeout_busy_cycles", 128'(rd_cycles), 128'(TMO));
      check_val("timeout_err_set", 128'(timeout_err), 128'(1));
      ctl_mode = 0;
      port_xfer(0, 1'b1, 1'b0, 24'h000020, '0, 0, 1'b0);
      check_val("timeout_then_idle", 128'(log_bits()), 128'(32'b01));
      check_val("timeout_err_sticky", 128'(timeout_err), 128'(1));
      check_val("timeout_zero_data", 128'(p1_data_out), 128'(0));

      // Reset pulled low mid-transfer.
      ctl_mode = 1;
      drive(0, 1'b0, 1'b1, 24'h000050, 32'h1234_5678);
      n = 0;
      while (!dram_req_write && n < 20) begin @(posedge clk); #1; n++; end
      check_val("rst_busy_reached", 128'(dram_req_write), 128'(1));
      repeat (2) begin @(posedge clk); #1; end
      #3 rst_n = 1'b0;
      #1;
      check_val("rst_mid_outputs", out_vec(), '0);
      drive(0, 1'b0, 1'b0, 24'h000050, '0);
      ctl_mode = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      grant_log.delete();
      repeat (10) begin @(posedge clk); #1; end
      check_val("rst_no_new_req", 128'(grant_log.size()), 128'(0));
      fork
         port_xfer(0, 1'b1, 1'b0, 24'h000050, '0, 0, 1'b0);
         port_xfer(1, 1'b1, 1'b0, 24'h800050, '0, 0, 1'b0);
      join
      check_val("rst_first_tie", 128'(log_bits()), 128'(32'b10));

      // Random traffic with spurious controller completions.
      noise_en = 1'b1;
      fork
         port_loop(0, 30);
         port_loop(1, 30);
      join
      noise_en = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      check_val("q0_drained", 128'(exp_q0.size()), 128'(0));
      check_val("q1_drained", 128'(exp_q1.size()), 128'(0));
      check_val("no_random_timeout", 128'(timeout_err), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
